// File: rtl/rx_pkt_arbiter.sv
// Two-input AXI-Stream packet arbiter feeding the filter RX pipeline.
// Grants are packet-granular, alternate between the two sources on contention
// and are held until the granted source delivers its tlast beat. The output
// stage is a single register slice with one cycle of latency.
`timescale 1ns / 1ps

module rx_pkt_arbiter #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned KEEP_W = 64,
  parameter int unsigned USER_W = 48
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              s0_axis_tvalid,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic [USER_W-1:0] s0_axis_tuser,
  output logic              s0_axis_tready,

  input  logic              s1_axis_tvalid,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic [USER_W-1:0] s1_axis_tuser,
  output logic              s1_axis_tready,

  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tid,
  input  logic              m_axis_tready,

  input  logic              arb_enable,
  output logic              arb_busy,
  output logic [31:0]       pkt_count0,
  output logic [31:0]       pkt_count1
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e state_q, state_d;
  // Source that won the most recent grant; the other one wins the next tie.
  logic   last_src_q, last_src_d;

  logic              m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic [KEEP_W-1:0] m_tkeep_q;
  logic              m_tlast_q;
  logic [USER_W-1:0] m_tuser_q;
  logic              m_tid_q;
  logic [31:0]       pkt_cnt0_q;
  logic [31:0]       pkt_cnt1_q;

  logic out_ready;
  logic acc0, acc1;

  // Output slice can take a new beat when empty or being drained this cycle.
  assign out_ready = !m_tvalid_q || m_axis_tready;
  assign acc0      = s0_axis_tvalid && s0_axis_tready;
  assign acc1      = s1_axis_tvalid && s1_axis_tready;

  // State register and round-robin pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      last_src_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
    end
  end

  // Next-state: grant in idle, release on the accepted tlast of the owner.
  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    unique case (state_q)
      StIdle: begin
        if (arb_enable) begin
          if (s0_axis_tvalid && s1_axis_tvalid) begin
            state_d = last_src_q ? StGrant0 : StGrant1;
          end else if (s0_axis_tvalid) begin
            state_d = StGrant0;
          end else if (s1_axis_tvalid) begin
            state_d = StGrant1;
          end
        end
      end
      StGrant0: begin
        if (acc0 && s0_axis_tlast) begin
          state_d    = StIdle;
          last_src_d = 1'b0;
        end
      end
      StGrant1: begin
        if (acc1 && s1_axis_tlast) begin
          state_d    = StIdle;
          last_src_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs: only the granted source sees ready.
  always_comb begin
    s0_axis_tready = (state_q == StGrant0) && out_ready;
    s1_axis_tready = (state_q == StGrant1) && out_ready;
    arb_busy       = (state_q != StIdle);
  end

  // Output register slice; holds everything while downstream stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tid_q    <= 1'b0;
    end else if (out_ready) begin
      m_tvalid_q <= acc0 || acc1;
      if (acc0) begin
        m_tdata_q <= s0_axis_tdata;
        m_tkeep_q <= s0_axis_tkeep;
        m_tlast_q <= s0_axis_tlast;
        m_tuser_q <= s0_axis_tuser;
        m_tid_q   <= 1'b0;
      end else if (acc1) begin
        m_tdata_q <= s1_axis_tdata;
        m_tkeep_q <= s1_axis_tkeep;
        m_tlast_q <= s1_axis_tlast;
        m_tuser_q <= s1_axis_tuser;
        m_tid_q   <= 1'b1;
      end
    end
  end

  // Per-source packet counters, bumped on each accepted tlast; wrap naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      if (acc0 && s0_axis_tlast) pkt_cnt0_q <= pkt_cnt0_q + 32'd1;
      if (acc1 && s1_axis_tlast) pkt_cnt1_q <= pkt_cnt1_q + 32'd1;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tid    = m_tid_q;
  assign pkt_count0    = pkt_cnt0_q;
  assign pkt_count1    = pkt_cnt1_q;

endmodule
